// File: rtl/mdu_issue_if.sv
// Bundles the E-stage decode, pipeline control and MDU status signals of the MDU issue controller.
// The controller connects through the slave modport. The pipeline/MDU side connects through the master modport.
interface mdu_issue_if #(
  parameter int CNT_W = 4
);
  logic             e_valid;
  logic             e_md;
  logic             e_div;
  logic             e_mt;
  logic             e_mf;
  logic             flush;
  logic             hold;
  logic             mdu_busy;
  logic             mdu_en;
  logic             stall;
  logic             busy_trk;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic             mismatch;

  modport slave (
    input  e_valid, e_md, e_div, e_mt, e_mf, flush, hold, mdu_busy,
    output mdu_en, stall, busy_trk, cnt, state, mismatch
  );

  modport master (
    output e_valid, e_md, e_div, e_mt, e_mf, flush, hold, mdu_busy,
    input  mdu_en, stall, busy_trk, cnt, state, mismatch
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue/interlock controller for the multiply/divide unit.
// It tracks the fixed-latency MDU busy window and stalls the pipeline on HI/LO hazards.
module mdu_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  mdu_issue_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MULT_RUN = 2'b01,
    DIV_RUN  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch_q, mismatch_d;

  logic busy_trk;
  logic hilo_op;
  logic issue_op;
  logic hazard;
  logic mdu_en;
  logic stall;

  assign busy_trk = (state_q != IDLE);
  assign hilo_op  = bus.e_md | bus.e_mt | bus.e_mf;
  // mf reads HI/LO directly once the window closes, so it never needs the MDU enable.
  assign issue_op = bus.e_md | bus.e_mt;
  assign hazard   = bus.e_valid & hilo_op & busy_trk;

  // Async reset clears state_q immediately. The explicit reset term also holds the pulses low
  // while reset is active.
  assign stall  = ~reset & hazard & ~bus.flush;
  assign mdu_en = ~reset & bus.e_valid & issue_op & ~busy_trk & ~bus.flush & ~bus.hold;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // e_md wins over a simultaneous e_mt. An mt issue writes HI/LO without starting a window.
        if (mdu_en && bus.e_md) begin
          if (bus.e_div) begin
            state_d = DIV_RUN;
            cnt_d   = DIV_LOAD;
          end else begin
            state_d = MULT_RUN;
            cnt_d   = MULT_LOAD;
          end
        end
      end
      MULT_RUN, DIV_RUN: begin
        // The MDU cannot abort, so flush has no effect here. A zero count is treated as done.
        if (cnt_q <= CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mismatch_d = mismatch_q | (busy_trk != bus.mdu_busy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign bus.mdu_en   = mdu_en;
  assign bus.stall    = stall;
  assign bus.busy_trk = busy_trk;
  assign bus.cnt      = cnt_q;
  assign bus.state    = state_q;
  assign bus.mismatch = mismatch_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scenario bench for mdu_issue_ctrl: per-cycle expectations are queued at drive time and checked at mid-cycle.
// mdu_busy is driven from each scenario's own expected busy window, which stands in for a well-behaved MDU.
module tb_mdu_issue_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_issue_if #(.CNT_W(4)) bus ();

  mdu_issue_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic       en;
    logic       stall;
    logic       busy;
    logic [3:0] cnt;
    logic [1:0] st;
    logic       mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk(input logic en, input logic stall, input logic busy,
                              input logic [3:0] cnt, input logic [1:0] st, input logic mis);
    return {en, stall, busy, cnt, st, mis};
  endfunction

  function automatic exp_t sample();
    return {bus.mdu_en, bus.stall, bus.busy_trk, bus.cnt, bus.state, bus.mismatch};
  endfunction

  // Inputs change 1 time unit after the rising edge. They are sampled 3 units later.
  task automatic drive(input logic v, input logic md, input logic dv, input logic mt,
                       input logic mf, input logic fl, input logic hd, input logic mb);
    @(posedge clk);
    #1;
    bus.e_valid  = v;
    bus.e_md     = md;
    bus.e_div    = dv;
    bus.e_mt     = mt;
    bus.e_mf     = mf;
    bus.flush    = fl;
    bus.hold     = hd;
    bus.mdu_busy = mb;
  endtask

  task automatic test_reset();
    exp_t obs, e;
    reset        = 1'b1;
    bus.e_valid  = 1'b1;
    bus.e_md     = 1'b1;
    bus.e_div    = 1'b0;
    bus.e_mt     = 1'b0;
    bus.e_mf     = 1'b0;
    bus.flush    = 1'b0;
    bus.hold     = 1'b0;
    bus.mdu_busy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
      if (c == 0) #2;
      else begin
        @(posedge clk);
        #4;
      end
      obs = sample();
      e   = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset c=%0d got=%b exp=%b (en,stall,busy,cnt,state,mis)", c, obs, e);
      end else $display("txn reset c=%0d state=%0d cnt=%0d", c, obs.st, obs.cnt);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    exp_t obs, e;
    logic b;
    for (int c = 0; c <= 6; c++) begin
      b = (c >= 1 && c <= 5);
      drive(c == 0, c == 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b);
      exp_q.push_back(mk(c == 0, 1'b0, b, b ? 4'(6 - c) : 4'd0, b ? 2'd1 : 2'd0, 1'b0));
      #3;
      obs = sample();
      e   = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mult c=%0d got=%b exp=%b (en,stall,busy,cnt,state,mis)", c, obs, e);
      end else $display("txn mult c=%0d en=%b busy=%b cnt=%0d", c, obs.en, obs.busy, obs.cnt);
    end
  endtask

  task automatic test_div_mf();
    exp_t obs, e;
    logic b;
    for (int c = 0; c <= 12; c++) begin
      b = (c >= 1 && c <= 10);
      if (c == 0) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, b);
      else if (c <= 11) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b);
      else drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b);
      exp_q.push_back(mk(c == 0, b, b, b ? 4'(11 - c) : 4'd0, b ? 2'd2 : 2'd0, 1'b0));
      #3;
      obs = sample();
      e   = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL div_mf c=%0d got=%b exp=%b (en,stall,busy,cnt,state,mis)", c, obs, e);
      end else $display("txn div_mf c=%0d stall=%b cnt=%0d", c, obs.stall, obs.cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t obs, e;
    logic b;
    logic [3:0] k;
    for (int c = 0; c <= 12; c++) begin
      b = (c >= 1 && c <= 5) || (c >= 7 && c <= 11);
      k = (c >= 1 && c <= 5) ? 4'(6 - c) : (c >= 7 && c <= 11) ? 4'(12 - c) : 4'd0;
      drive(c <= 6, c <= 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b);
      exp_q.push_back(mk(c == 0 || c == 6, c >= 1 && c <= 5, b, k, b ? 2'd1 : 2'd0, 1'b0));
      #3;
      obs = sample();
      e   = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL b2b c=%0d got=%b exp=%b (en,stall,busy,cnt,state,mis)", c, obs, e);
      end else $display("txn b2b c=%0d en=%b stall=%b cnt=%0d", c, obs.en, obs.stall, obs.cnt);
    end
  endtask

  task automatic test_mt();
    exp_t obs, e;
    logic b;
    for (int c = 0; c <= 14; c++) begin
      b = (c >= 3 && c <= 12);
      if (c == 0 || (c >= 3 && c <= 13)) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, b);
      else if (c == 2) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, b);
      else drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b);
      exp_q.push_back(mk(c == 0 || c == 2 || c == 13, b, b, b ? 4'(13 - c) : 4'd0,
                         b ? 2'd2 : 2'd0, 1'b0));
      #3;
      obs = sample();
      e   = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mt c=%0d got=%b exp=%b (en,stall,busy,cnt,state,mis)", c, obs, e);
      end else $display("txn mt c=%0d en=%b state=%0d", c, obs.en, obs.st);
    end
  endtask

  task automatic test_flush();
    exp_t obs, e;
    logic b;
    for (int c = 0; c <= 15; c++) begin
      b = (c >= 1 && c <= 10);
      case (c)
        0:       drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, b);
        3:       drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, b);
        12:      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, b);
        13:      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, b);
        14:      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, b);
        default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b);
      endcase
      exp_q.push_back(mk(c == 0, 1'b0, b, b ? 4'(11 - c) : 4'd0, b ? 2'd2 : 2'd0, 1'b0));
      #3;
      obs = sample();
      e   = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL flush c=%0d got=%b exp=%b (en,stall,busy,cnt,state,mis)", c, obs, e);
      end else $display("txn flush c=%0d en=%b stall=%b cnt=%0d", c, obs.en, obs.stall, obs.cnt);
    end
  endtask

  task automatic test_reset_mid_and_mismatch();
    exp_t obs, e;
    logic b;
    // Conflicting md+mt decode issues as a div.
    for (int c = 0; c <= 4; c++) begin
      b = (c >= 1);
      if (c == 0) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, b);
      else drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b);
      exp_q.push_back(mk(c == 0, 1'b0, b, b ? 4'(11 - c) : 4'd0, b ? 2'd2 : 2'd0, 1'b0));
      #3;
      obs = sample();
      e   = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rstmid c=%0d got=%b exp=%b (en,stall,busy,cnt,state,mis)", c, obs, e);
      end else $display("txn rstmid c=%0d cnt=%0d", c, obs.cnt);
    end
    #1;
    reset        = 1'b1;
    bus.mdu_busy = 1'b0;
    bus.e_valid  = 1'b1;
    bus.e_md     = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    #2;
    obs = sample();
    e   = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b (en,stall,busy,cnt,state,mis)", obs, e);
    end else $display("txn async_reset state=%0d cnt=%0d", obs.st, obs.cnt);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    // One idle cycle with a spurious MDU busy, then mismatch must stick.
    for (int c = 0; c <= 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c == 0);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, c >= 1));
      #3;
      obs = sample();
      e   = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mismatch c=%0d got=%b exp=%b (en,stall,busy,cnt,state,mis)", c, obs, e);
      end else $display("txn mismatch c=%0d mis=%b", c, obs.mis);
    end
    reset = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0));
    #2;
    obs = sample();
    e   = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL mismatch_clear got=%b exp=%b (en,stall,busy,cnt,state,mis)", obs, e);
    end else $display("txn mismatch_clear mis=%b", obs.mis);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_div_mf();
    test_back_to_back();
    test_mt();
    test_flush();
    test_reset_mid_and_mismatch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
